// File: rtl/fsync_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fsync_pkg
//  Description : Shared helpers for fsync consumers. Derives the channel-index
//                width, gives the pending-counter ceiling and extracts one
//                count field from a packed multi-channel count bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsync_pkg;

   // Widest packed count bus the slice helper accepts.
   localparam int unsigned c_FIELD_BUS_W = 512;

   // Returns ceil(log2(n)), but never less than 1, so a 1-bit index still exists.
   function automatic int unsigned chw_of(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Largest value a pw-bit saturating counter holds.
   function automatic logic [31:0] pend_max(input int unsigned pw);
      return (pw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pw) - 32'd1);
   endfunction

   // Field idx of width w from a packed count bus; the caller narrows the result.
   function automatic logic [31:0] cnt_field(input logic [c_FIELD_BUS_W-1:0] bus,
                                             input int unsigned          idx,
                                             input int unsigned          w);
      logic [c_FIELD_BUS_W-1:0] mask;
      mask = (c_FIELD_BUS_W'(1) << w) - c_FIELD_BUS_W'(1);
      return 32'((bus >> (idx * w)) & mask);
   endfunction

endpackage : fsync_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches ptr+1, ptr+2, ...
//                modulo NCH and grants the first requesting index. The wrap is
//                at NCH, so non-power-of-2 channel counts are handled.
//  Ports       : req     - request vector, one bit per index
//                ptr     - index granted last; search starts just above it
//                gnt_vld - at least one request is present
//                gnt_idx - granted index (0 when gnt_vld is low)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CHW-1:0] ptr,
   output logic           gnt_vld,
   output logic [CHW-1:0] gnt_idx
);

   logic           w_hi_vld;
   logic [CHW-1:0] w_hi_idx;
   logic           w_lo_vld;
   logic [CHW-1:0] w_lo_idx;

   // Two priority searches: lowest request strictly above ptr, and lowest
   // request overall. The first one wins, and the second covers the wrap.
   // Scanning downward leaves the lowest matching index in each result.
   always_comb begin
      w_hi_vld = 1'b0;
      w_hi_idx = '0;
      w_lo_vld = 1'b0;
      w_lo_idx = '0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (req[j] && ($unsigned(j) > 32'(ptr))) begin
            w_hi_vld = 1'b1;
            w_hi_idx = CHW'(j);
         end
         if (req[j]) begin
            w_lo_vld = 1'b1;
            w_lo_idx = CHW'(j);
         end
      end
   end

   assign gnt_vld = w_lo_vld;
   assign gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;

endmodule : rr_pick
`default_nettype wire

// File: rtl/fsync_event_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fsync_event_arb
//  Description : Accumulates per-channel flag counts into saturating pending
//                counters. Events are sent one per transfer on a single
//                valid/ready output, round-robin across the channels.
//  Ports       : clk       - destination clock
//                rst_n     - asynchronous active-low reset
//                en        - scheduling enable (counts accumulate regardless)
//                in_cnt    - packed per-channel flag counts, IW bits each
//                out_valid - event presented
//                out_ready - consumer accepts when high with out_valid
//                out_ch    - channel of the presented event
//                pend_nz   - registered pending != 0 per channel
//                ovf       - sticky per-channel saturation loss flags
//                ovf_clr   - clears all ovf bits
//  Revision    : 1.0 - initial release
// ============================================================================
module fsync_event_arb
   import fsync_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = 4,
   parameter int PW  = 8,
   parameter int CHW = int'(chw_of(NCH))
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NCH*IW-1:0] in_cnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHW-1:0]    out_ch,
   output logic [NCH-1:0]    pend_nz,
   output logic [NCH-1:0]    ovf,
   input  logic              ovf_clr
);

   localparam logic [PW-1:0] c_PEND_MAX = PW'(pend_max(PW));

   logic           r_out_valid;
   logic [CHW-1:0] r_out_ch;
   logic [CHW-1:0] r_rr_ptr;
   logic [NCH-1:0] r_pend_nz;
   logic [NCH-1:0] r_ovf;

   logic           w_gnt_vld;
   logic [CHW-1:0] w_gnt_idx;
   logic           w_load;
   logic [NCH-1:0] w_next_nz;
   logic [NCH-1:0] w_sat;

   // Selection looks only at registered state, so out_valid never feeds back
   // combinationally into the picker.
   rr_pick #(
      .NCH (NCH),
      .CHW (CHW)
   ) u_rr_pick (
      .req     (r_pend_nz),
      .ptr     (r_rr_ptr),
      .gnt_vld (w_gnt_vld),
      .gnt_idx (w_gnt_idx)
   );

   // gnt_vld equals |pend_nz. A held (unaccepted) output blocks loading.
   assign w_load = en && (!r_out_valid || out_ready) && w_gnt_vld;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [IW-1:0] w_cnt;
      logic          w_dec;
      logic [PW:0]   w_sum;
      logic [PW-1:0] w_next;
      logic [PW-1:0] r_pend;

      assign w_cnt = IW'(cnt_field(c_FIELD_BUS_W'(in_cnt), gi, IW));
      assign w_dec = w_load && (w_gnt_idx == CHW'(gi));

      // One spare bit catches saturation. The decrement cannot underflow
      // because only a channel with pending >= 1 can win.
      assign w_sum  = {1'b0, r_pend} + (PW + 1)'(w_cnt) - (PW + 1)'(w_dec);
      assign w_sat[gi]     = (w_sum > {1'b0, c_PEND_MAX});
      assign w_next        = w_sat[gi] ? c_PEND_MAX : w_sum[PW-1:0];
      assign w_next_nz[gi] = (w_next != '0);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_pend <= '0;
         end else begin
            r_pend <= w_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_nz <= '0;
         r_ovf     <= '0;
      end else begin
         r_pend_nz <= w_next_nz;
         // A same-cycle saturation overrides the clear.
         r_ovf     <= w_sat | (ovf_clr ? '0 : r_ovf);
      end
   end

   // Reset points the pointer at the last channel so channel 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_rr_ptr    <= CHW'(NCH - 1);
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_ch    <= w_gnt_idx;
         r_rr_ptr    <= w_gnt_idx;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;
   assign pend_nz   = r_pend_nz;
   assign ovf       = r_ovf;

endmodule : fsync_event_arb
`default_nettype wire

// File: tb/tb_fsync_event_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsync_event_arb
//  Description : Directed self-checking bench for fsync_event_arb (NCH=4,
//                IW=4, PW=8). Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsync_event_arb;

   localparam int NCH = 4;
   localparam int IW  = 4;
   localparam int PW  = 8;
   localparam int CHW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [NCH*IW-1:0] in_cnt;
   logic              out_valid;
   logic              out_ready;
   logic [CHW-1:0]    out_ch;
   logic [NCH-1:0]    pend_nz;
   logic [NCH-1:0]    ovf;
   logic              ovf_clr;

   int n_checks = 0;
   int n_errors = 0;
   int ev_cnt [NCH];
   int ev_seq [$];
   int exp_rr_seq [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};

   always #5 clk = ~clk;

   fsync_event_arb #(
      .NCH (NCH),
      .IW  (IW),
      .PW  (PW),
      .CHW (CHW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_cnt    (in_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .pend_nz   (pend_nz),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en        = 1'b0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      in_cnt    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Accepts events with out_ready high until nothing is presented or pending.
   task automatic drain(input int max_cyc);
      bit done;
      done = 1'b0;
      ev_seq.delete();
      for (int k = 0; k < NCH; k++) ev_cnt[k] = 0;
      out_ready = 1'b1;
      for (int c = 0; c < max_cyc && !done; c++) begin
         if (out_valid) begin
            ev_seq.push_back(int'(out_ch));
            ev_cnt[out_ch]++;
            tick();
         end else if (pend_nz == '0) begin
            done = 1'b1;
         end else begin
            tick();
         end
      end
      if (!done) check("drain_bound", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state and single-event latency.
      do_reset();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ch",    32'(out_ch),    32'd0);
      check("rst_nz",    32'(pend_nz),   32'd0);
      check("rst_ovf",   32'(ovf),       32'd0);
      en = 1'b1; out_ready = 1'b1;
      in_cnt = 16'h0100;
      tick();
      in_cnt = '0;
      check("se_t1_valid", 32'(out_valid), 32'd0);
      check("se_t1_nz",    32'(pend_nz),   32'h4);
      tick();
      check("se_t2_valid", 32'(out_valid), 32'd1);
      check("se_t2_ch",    32'(out_ch),    32'd2);
      check("se_t2_nz",    32'(pend_nz),   32'd0);
      tick();
      check("se_t3_valid", 32'(out_valid), 32'd0);

      // Round-robin fairness over ch0, ch1, ch3.
      do_reset();
      out_ready = 1'b1;
      in_cnt = 16'h3033;
      tick();
      in_cnt = '0;
      check("rr_pre_nz",    32'(pend_nz),   32'hB);
      check("rr_pre_valid", 32'(out_valid), 32'd0);
      en = 1'b1;
      drain(40);
      check("rr_count", 32'(ev_seq.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("rr_seq%0d", i),
               (i < ev_seq.size()) ? 32'(ev_seq[i]) : 32'hFFFF_FFFF,
               32'(exp_rr_seq[i]));
      end
      check("rr_end_valid", 32'(out_valid), 32'd0);

      // Backpressure: ch1 held for 5 cycles while ch0 gains 2 counts.
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      in_cnt = 16'h0010;
      tick();
      in_cnt = 16'h0001;
      tick();
      in_cnt = 16'h0001;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp_hold%0d_ch", k),    32'(out_ch),    32'd1);
         if (k < 4) begin
            tick();
            in_cnt = '0;
         end
      end
      out_ready = 1'b1;
      tick();
      check("bp_a_valid", 32'(out_valid), 32'd1);
      check("bp_a_ch",    32'(out_ch),    32'd0);
      tick();
      check("bp_b_valid", 32'(out_valid), 32'd1);
      check("bp_b_ch",    32'(out_ch),    32'd0);
      tick();
      check("bp_end_valid", 32'(out_valid), 32'd0);

      // Simultaneous add and take on ch0: 1 + 4 - 1 leaves 4 behind.
      do_reset();
      out_ready = 1'b1;
      in_cnt = 16'h0001;
      tick();
      en = 1'b1;
      in_cnt = 16'h0004;
      tick();
      in_cnt = '0;
      check("sim_valid", 32'(out_valid), 32'd1);
      check("sim_ch",    32'(out_ch),    32'd0);
      check("sim_nz",    32'(pend_nz),   32'h1);
      drain(20);
      check("sim_ch0_events", 32'(ev_cnt[0]),     32'd5);
      check("sim_total",      32'(ev_seq.size()), 32'd5);

      // Saturation on ch1 and sticky overflow.
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      in_cnt = 16'h00F0;
      repeat (20) tick();
      in_cnt = '0;
      check("sat_ovf",   32'(ovf),       32'h2);
      check("sat_nz",    32'(pend_nz),   32'h2);
      check("sat_valid", 32'(out_valid), 32'd1);
      check("sat_ch",    32'(out_ch),    32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sat_clr_alone", 32'(ovf), 32'h0);
      ovf_clr = 1'b1;
      in_cnt  = 16'h00F0;
      tick();
      ovf_clr = 1'b0;
      in_cnt  = '0;
      check("sat_clr_vs_sat", 32'(ovf), 32'h2);
      // 255 pending plus the one already presented.
      drain(400);
      check("sat_ch1_events", 32'(ev_cnt[1]),     32'd256);
      check("sat_total",      32'(ev_seq.size()), 32'd256);

      // Enable gating: counts accumulate while en is low.
      do_reset();
      out_ready = 1'b1;
      in_cnt = 16'h0100;
      tick();
      tick();
      in_cnt = '0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("en_off%0d_valid", k), 32'(out_valid), 32'd0);
         tick();
      end
      check("en_off_nz", 32'(pend_nz), 32'h4);
      en = 1'b1;
      drain(20);
      check("en_ch2_events", 32'(ev_cnt[2]),     32'd2);
      check("en_total",      32'(ev_seq.size()), 32'd2);
      check("en_end_valid",  32'(out_valid),     32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fsync_event_arb
`default_nettype wire

// File: doc/fsync_event_arb.md
Name: fsync_event_arb

Overview:
- Per-channel event scheduler downstream of a bank of fsync flag synchronizers, all in the destination clock domain.
- Each channel delivers a per-cycle flag count. The block accumulates the counts into saturating pending counters.
- It then serializes the events, one per transfer, onto a single valid/ready output, round-robin across channels.
- Consumers are shared single-event resources, e.g. a doorbell queue or a completion-credit return path.

Parameters:
- NCH, 4, number of channels (2..16).
- IW, 4, width of each channel's incoming flag-count field; matches the fsync count-output width for the chosen ratio.
- PW, 8, width of each pending counter; saturates at 2^PW-1.
- CHW, derived = max(1, ceil(log2(NCH))), width of the channel index.

Ports:
- clk  in  1  destination clock, same clock as the fsync output side.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scheduling enable; counts still accumulate while low.
- in_cnt  in  NCH*IW  channel i's count in bits [i*IW +: IW]; flags arriving this cycle.
- out_valid  out  1  an event is presented.
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high.
- out_ch  out  CHW  channel index of the presented event.
- pend_nz  out  NCH  pending[i] != 0, registered view.
- ovf  out  NCH  sticky: channel i lost events to saturation.
- ovf_clr  in  1  clears all ovf bits; single-cycle pulse.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - pending = 0, out_valid = 0, out_ch = 0, pend_nz = 0, ovf = 0.
  - rr_ptr = NCH-1, so channel 0 wins the first arbitration.
- Load condition: load = en and (!out_valid or out_ready) and |pend_nz.
  - When load is true, the output register takes winner w: out_valid <= 1, out_ch <= w.
  - On the same edge, pending[w] is decremented and rr_ptr <= w.
- Idle: if the output was accepted (out_valid and out_ready) and load is false, out_valid <= 0.
- Stability: while out_valid and !out_ready, out_valid and out_ch hold, and no load occurs, regardless of en.
- Arbitration: round-robin over pend_nz. Search order is rr_ptr+1, rr_ptr+2, … modulo NCH. The first nonzero channel wins. Selection is combinational from registered state only.
- Counter update per channel, computed in PW+1 bits:
  - sum = pending[i] + in_cnt[i] - (load and w==i).
  - If sum > 2^PW-1: pending[i] <= 2^PW-1 and ovf[i] <= 1.
  - Otherwise pending[i] <= sum.
- Simultaneous increment and decrement on the same channel resolve by net arithmetic, as above. A decrement never underflows, because the winner has pending ≥ 1.
- ovf_clr has priority below a same-cycle saturation: if both occur, ovf[i] stays 1.
- pend_nz[i] is registered and equals (next pending[i] != 0).
- Latency: a count presented at cycle t raises pend_nz at t+1. out_valid is raised at t+2 at the earliest, when the output is idle and the channel wins.
- Throughput: one event per cycle sustained while out_ready = 1.
- en low:
  - No new loads.
  - A presented event remains valid until accepted.
  - Counters keep accumulating.
- Wrap-around: rr_ptr = NCH-1 searches from channel 0. For non-power-of-2 NCH, the index wraps at NCH, not at 2^CHW.
- Reset mid-transfer drops any presented event and all pending counts. The consumer must tolerate this loss.

Decomposition:
- Package fsync_pkg holds:
  - the CHW derivation function (clog2-style);
  - the pending-counter maximum constant expression;
  - the count-field slice helper shared with other fsync consumers.
- One sub-module, rr_pick:
  - combinational round-robin picker;
  - inputs: req[NCH], ptr[CHW];
  - outputs: gnt_vld, gnt_idx[CHW].
  - It is reused by other arbiters in the PCIe/AXI path.

Test Plan:
- Reset/single event: after reset, drive in_cnt ch2 = 1 for one cycle with out_ready = 1.
  - Response: out_valid high exactly 2 cycles later for one cycle, out_ch = 2, pend_nz ends at 0.
- Round-robin fairness: preload ch0 = 3, ch1 = 3, ch3 = 3, then hold out_ready = 1.
  - Response: out_ch sequence 0,1,3,0,1,3,0,1,3, then out_valid = 0.
- Backpressure: with one event presented on ch1 and out_ready = 0 for 5 cycles while ch0 gains 2 counts.
  - Response: out_valid/out_ch = 1 held stable for all 5 cycles.
  - After out_ready rises: accepted, then ch0 presented next cycle, twice.
- Simultaneous add/take: ch0 pending = 1, in_cnt ch0 = 4 on the same cycle ch0 loads.
  - Response: pending becomes 4, and exactly 5 total ch0 events are delivered.
- Saturation: PW = 8, out_ready = 0, drive in_cnt ch1 = 15 for 20 cycles.
  - Response: pending[1] = 255, ovf[1] = 1.
  - ovf_clr alone clears it.
  - ovf_clr together with a further saturating add leaves ovf[1] = 1.
- en gating: en = 0 with ch2 pending = 2.
  - Response: no out_valid rise, counts still accumulate.
  - Raise en: 2 events delivered on out_ch = 2, then out_valid = 0.
